// File: rtl/dac0_vtgt_seq_if.sv
// DAC0 voltage-target sequencer bus: register-bank side inputs and DAC0-side outputs.
interface dac0_vtgt_seq_if;
  logic        upd;
  logic [10:0] tgt;
  logic        hlsb;
  logic [15:0] cvofs;
  logic [10:0] dac_code;
  logic        busy;
  logic        done;
  logic        dith_ph;

  modport master (output upd, tgt, hlsb, cvofs, input dac_code, busy, done, dith_ph);
  modport slave  (input upd, tgt, hlsb, cvofs, output dac_code, busy, done, dith_ph);
endinterface

// File: rtl/dac0_vtgt_seq.sv
// DAC0 voltage-target sequencer: offset/saturate target, slew, settle, optional half-LSB dither.
// Define DAC0_SLEW_RAMP_EN for 1-LSB-per-SLEW_DIV ramping; otherwise the code loads directly.
module dac0_vtgt_seq #(
  parameter int SLEW_DIV   = 16,
  parameter int SETTLE_CYC = 64,
  parameter int DITH_DIV   = 32
) (
  input logic           clk,
  input logic           rst,
  dac0_vtgt_seq_if.slave bus
);

  localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int DW = (DITH_DIV > 1) ? $clog2(DITH_DIV) : 1;

  if (SLEW_DIV < 1 || SETTLE_CYC < 1 || DITH_DIV < 1) begin : g_bad_param
    $error("dac0_vtgt_seq: SLEW_DIV, SETTLE_CYC and DITH_DIV must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, RAMP, SETTLE, HOLD} state_t;

  state_t        state, state_n;
  logic [10:0]   code_q, e_q, e_new;
  logic          hlsb_q;
  logic [TW-1:0] set_cnt;
  logic [DW-1:0] dith_cnt;
  logic          dith_q;
  logic [1:0]    seg;
  logic [3:0]    ofs;
  logic [11:0]   sum;
  logic          set_last, at_tgt, dith_on, busy, done;

  // Offset segment chosen from the incoming target; sum saturates at full scale.
  always_comb begin
    if (bus.tgt < 11'd256)      seg = 2'd0;
    else if (bus.tgt < 11'd512) seg = 2'd1;
    else if (bus.tgt < 11'd768) seg = 2'd2;
    else                        seg = 2'd3;
    ofs   = bus.cvofs[{seg, 2'b00} +: 4];
    sum   = {1'b0, bus.tgt} + {8'd0, ofs};
    e_new = sum[11] ? 11'h7FF : sum[10:0];
  end

  assign set_last = (set_cnt == TW'(SETTLE_CYC - 1));
  assign at_tgt   = (code_q == e_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // upd always wins: it restarts the move from any state and swallows a coincident done.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (bus.upd) state_n = RAMP;
      RAMP: begin
        busy = 1'b1;
`ifdef DAC0_SLEW_RAMP_EN
        if (!bus.upd && at_tgt) state_n = SETTLE;
`else
        if (!bus.upd) state_n = SETTLE;
`endif
      end
      SETTLE: begin
        if (bus.upd) begin
          busy    = 1'b1;
          state_n = RAMP;
        end else if (set_last) begin
          done    = 1'b1;
          state_n = HOLD;
        end else begin
          busy = 1'b1;
        end
      end
      HOLD: if (bus.upd) state_n = RAMP;
      default: state_n = IDLE;
    endcase
  end

`ifdef DAC0_SLEW_RAMP_EN
  localparam int SW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  logic [SW-1:0] slew_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q   <= '0;
      e_q      <= '0;
      hlsb_q   <= 1'b0;
      set_cnt  <= '0;
      dith_cnt <= '0;
      dith_q   <= 1'b0;
`ifdef DAC0_SLEW_RAMP_EN
      slew_cnt <= '0;
`endif
    end else begin
      if (bus.upd) begin
        e_q    <= e_new;
        hlsb_q <= bus.hlsb;
      end
      set_cnt <= (state == SETTLE && !bus.upd && !set_last) ? set_cnt + 1'b1 : '0;
      // Dither only when code+1 still fits; anything else parks the phase at 0.
      if (state == HOLD && !bus.upd && hlsb_q && e_q != 11'h7FF) begin
        if (dith_cnt == DW'(DITH_DIV - 1)) begin
          dith_cnt <= '0;
          dith_q   <= ~dith_q;
        end else begin
          dith_cnt <= dith_cnt + 1'b1;
        end
      end else begin
        dith_cnt <= '0;
        dith_q   <= 1'b0;
      end
`ifdef DAC0_SLEW_RAMP_EN
      if (state == RAMP && !bus.upd && !at_tgt) begin
        if (slew_cnt == SW'(SLEW_DIV - 1)) begin
          slew_cnt <= '0;
          code_q   <= (code_q < e_q) ? code_q + 1'b1 : code_q - 1'b1;
        end else begin
          slew_cnt <= slew_cnt + 1'b1;
        end
      end else begin
        slew_cnt <= '0;
      end
`else
      if (state == RAMP && !bus.upd) code_q <= e_q;
`endif
    end
  end

  // code_q holds the base E in HOLD, so the +1 phase never overflows.
  assign dith_on      = (state == HOLD) && dith_q && !bus.upd;
  assign bus.dac_code = code_q + {10'd0, dith_on};
  assign bus.dith_ph  = dith_on;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule

// File: tb/tb_dac0_vtgt_seq.sv
// Directed bench for dac0_vtgt_seq (SLEW_DIV=4, SETTLE_CYC=8, DITH_DIV=32).
module tb_dac0_vtgt_seq;
  localparam int SLEW = 4;
  localparam int SETL = 8;
`ifdef DAC0_SLEW_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   done_tot = 0;
  int   n;
  int   base;

  dac0_vtgt_seq_if bus ();

  dac0_vtgt_seq #(.SLEW_DIV(SLEW), .SETTLE_CYC(SETL), .DITH_DIV(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_tot++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_upd(input logic [10:0] t, input logic [15:0] c, input logic h);
    bus.tgt   = t;
    bus.cvofs = c;
    bus.hlsb  = h;
    bus.upd   = 1'b1;
    @(posedge clk);
    #1;
    bus.upd = 1'b0;
  endtask

  // Clocks from the upd edge until done shows; stops at maxc.
  task automatic wait_done(input int start, input int maxc, output int cnt);
    cnt = start;
    while (bus.done !== 1'b1 && cnt < maxc) begin
      tick(1);
      cnt++;
    end
  endtask

  function automatic int exp_n(input int steps);
    return RAMP_EN ? steps * SLEW + SETL : SETL;
  endfunction

  initial begin
    bus.upd = 1'b0; bus.tgt = '0; bus.cvofs = '0; bus.hlsb = 1'b0;
    tick(3);
    chk("rst_code", 32'(bus.dac_code), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_dith", 32'(bus.dith_ph), 0);
    rst = 1'b0;
    tick(1);

    // plain ramp to 300
    do_upd(11'd300, 16'h0000, 1'b0);
    tick(3);
    chk("t2_code3", 32'(bus.dac_code), RAMP_EN ? 0 : 300);
    chk("t2_busy", 32'(bus.busy), 1);
    tick(1);
    chk("t2_code4", 32'(bus.dac_code), RAMP_EN ? 1 : 300);
    wait_done(4, 10000, n);
    chk("t2_done_n", 32'(n), 32'(exp_n(300)));
    chk("t2_busy_done", 32'(bus.busy), 0);
    tick(1);
    chk("t2_done_pulse", 32'(bus.done), 0);
    chk("t2_code_hold", 32'(bus.dac_code), 300);

    // offsets and segments
    do_upd(11'd600, 16'h4321, 1'b0);
    wait_done(0, 10000, n);
    chk("t3_seg2_n", 32'(n), 32'(exp_n(303)));
    chk("t3_seg2_code", 32'(bus.dac_code), 603);
    do_upd(11'd255, 16'h4321, 1'b0);
    wait_done(0, 10000, n);
    chk("t3_seg0_code", 32'(bus.dac_code), 256);
    do_upd(11'd256, 16'h4321, 1'b0);
    wait_done(0, 10000, n);
    chk("t3_seg1_n", 32'(n), 32'(exp_n(2)));
    chk("t3_seg1_code", 32'(bus.dac_code), 258);
    do_upd(11'd256, 16'h4321, 1'b0);
    tick(1);
    chk("t3_same_busy", 32'(bus.busy), 1);
    wait_done(1, 10000, n);
    chk("t3_same_n", 32'(n), SETL);

    // saturation, no dither at full scale
    do_upd(11'd2040, 16'hF000, 1'b1);
    wait_done(0, 10000, n);
    chk("t4_sat_code", 32'(bus.dac_code), 2047);
    tick(40);
    chk("t4_sat_dith", 32'(bus.dith_ph), 0);
    chk("t4_sat_hold", 32'(bus.dac_code), 2047);

    // dither at 100/101
    do_upd(11'd100, 16'h0000, 1'b1);
    wait_done(0, 10000, n);
    chk("t5_done_n", 32'(n), 32'(exp_n(1947)));
    tick(32);
    chk("t5_ph0_code", 32'(bus.dac_code), 100);
    chk("t5_ph0_dith", 32'(bus.dith_ph), 0);
    tick(1);
    chk("t5_ph1_code", 32'(bus.dac_code), 101);
    chk("t5_ph1_dith", 32'(bus.dith_ph), 1);
    tick(31);
    chk("t5_ph1_end", 32'(bus.dac_code), 101);
    tick(1);
    chk("t5_ph2_code", 32'(bus.dac_code), 100);
    tick(32);
    chk("t5_ph3_code", 32'(bus.dac_code), 101);
    bus.tgt = 11'd100; bus.cvofs = 16'h0000; bus.hlsb = 1'b0; bus.upd = 1'b1;
    #1;
    chk("t5_upd_code", 32'(bus.dac_code), 100);
    chk("t5_upd_dith", 32'(bus.dith_ph), 0);
    @(posedge clk);
    #1;
    bus.upd = 1'b0;
    wait_done(0, 10000, n);
    tick(80);
    chk("t5_steady_code", 32'(bus.dac_code), 100);
    chk("t5_steady_dith", 32'(bus.dith_ph), 0);

    // retarget mid-move, then a done swallowed by upd
    base = done_tot;
    do_upd(11'd200, 16'h0000, 1'b0);
    tick(RAMP_EN ? 200 : 3);
    chk("t6_mid_code", 32'(bus.dac_code), RAMP_EN ? 150 : 200);
    do_upd(11'd50, 16'h0000, 1'b0);
    tick(1);
    chk("t6_rev_code", 32'(bus.dac_code), RAMP_EN ? 150 : 50);
    wait_done(1, 10000, n);
    chk("t6_ret_n", 32'(n), 32'(exp_n(100)));
    chk("t6_ret_code", 32'(bus.dac_code), 50);
    tick(2);
    do_upd(11'd60, 16'h0000, 1'b0);
    wait_done(0, 10000, n);
    chk("t6_pre_n", 32'(n), 32'(exp_n(10)));
    bus.tgt = 11'd70; bus.upd = 1'b1;
    #1;
    chk("t6_supp_done", 32'(bus.done), 0);
    chk("t6_supp_busy", 32'(bus.busy), 1);
    @(posedge clk);
    #1;
    bus.upd = 1'b0;
    wait_done(0, 10000, n);
    chk("t6_last_n", 32'(n), 32'(exp_n(10)));
    chk("t6_last_code", 32'(bus.dac_code), 70);
    tick(3);
    chk("t6_done_count", 32'(done_tot - base), 2);

    // reset mid-move
    do_upd(11'd500, 16'h0000, 1'b0);
    tick(20);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_code", 32'(bus.dac_code), 0);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    base = done_tot;
    tick(40);
    chk("rst_mid_nodone", 32'(done_tot - base), 0);
    chk("rst_mid_idle", 32'(bus.dac_code), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
